cla_multiword_adder: RTL and testbench

- Sequential multi-precision adder/subtractor that consumes per-nibble group propagate/generate terms.
- A second-level lookahead unit resolves the nibble carries from those terms, and a carry register chains a WIDTH-bit slice across successive beats.
- Sits between the ALU operand path and the writeback path for long-word ADD/SUB (for example, a 64-bit add issued as 4 beats of 16).
- One registered output stage with a valid/ready handshake on both sides.

---
 rtl/cla_multiword_adder_if.sv | 51 +++++
 rtl/cla_multiword_adder.sv | 194 +++++++++++++++++++
 tb/tb_cla_multiword_adder.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_multiword_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_multiword_adder_if
// Purpose  : Beat-level handshake bundle for the multi-word CLA adder.
//            The input side carries one WIDTH-bit operand slice per beat, plus
//            chain framing (first/last) and the add/sub select.
//            The output side returns the registered result slice and its
//            flags.
// Signals  : in_valid/in_ready        - input beat handshake
//            in_a/in_b                - operand slices
//            in_sub/in_first/in_last  - op select and chain framing
//            out_valid/out_ready      - result beat handshake
//            out_sum/out_cout         - result slice and carry out
//            out_ovfl/out_zero        - chain flags, qualified by out_last
//            out_last/out_abort       - framing echo and interrupted-chain flag
// Modports : slave  - the adder
//            master - the producer/consumer driving it
// Revision : 1.0  initial release
// ============================================================================
interface cla_multiword_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovfl;
  logic             out_zero;
  logic             out_last;
  logic             out_abort;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovfl, out_zero,
           out_last, out_abort
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovfl, out_zero,
           out_last, out_abort
  );
endinterface
`default_nettype wire

// File: rtl/cla_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_multiword_adder
// Purpose  : Sequential multi-precision adder/subtractor.
//            Each accepted beat adds one WIDTH-bit slice, using a two-level
//            carry lookahead (nibble group P/G, then a flattened group-carry
//            unit).
//            A carry register chains successive slices, least-significant
//            slice first.
//            Results are registered once: latency is 1 and throughput is
//            1 beat/cycle.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - cla_multiword_adder_if.slave (input beat / result beat)
// Params   : WIDTH  - slice width, must be a multiple of 4
// Revision : 1.0  initial release
// ============================================================================
module cla_multiword_adder #(
  parameter int WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  cla_multiword_adder_if.slave    bus
);

  localparam int NG = WIDTH / 4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             carry_q;
  logic             sub_q;
  logic             zacc_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovfl_q;
  logic             out_zero_q;
  logic             out_last_q;
  logic             out_abort_q;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first_eff;
  logic             w_abort;
  logic             w_sub;
  logic             w_cin;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_pk;
  logic [NG-1:0]    w_gk;
  logic [NG:0]      w_c;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum;
  logic             w_zacc_d;

  // A slot is free when the output register is empty or is being drained
  // in this same cycle.
  assign w_in_ready = !out_valid_q | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // A beat arriving in IDLE always starts a chain, even without in_first.
  assign w_first_eff = bus.in_first | (state_q == S_IDLE);
  assign w_abort     = (state_q == S_IDLE) ? !bus.in_first : bus.in_first;

  assign w_sub   = w_first_eff ? bus.in_sub : sub_q;
  assign w_cin   = w_first_eff ? w_sub : carry_q;
  assign w_b_eff = w_sub ? ~bus.in_b : bus.in_b;
  assign w_p     = bus.in_a | w_b_eff;
  assign w_g     = bus.in_a & w_b_eff;

  // Group carry c[k+1], written as a flat OR of product terms:
  // (cin & P0..Pk) | OR over j of (Gj & Pj+1..Pk).
  // The loops unroll into parallel terms, so no carry ripples between
  // nibbles.
  function automatic logic f_group_carry(
    input logic [NG-1:0] gk,
    input logic [NG-1:0] pk,
    input logic          cin,
    input int            k
  );
    logic r;
    logic t;
    r = cin;
    for (int m = 0; m <= k; m++) r = r & pk[m];
    for (int j = 0; j <= k; j++) begin
      t = gk[j];
      for (int m = j + 1; m <= k; m++) t = t & pk[m];
      r = r | t;
    end
    return r;
  endfunction

  assign w_c[0] = w_cin;

  for (genvar k = 0; k < NG; k++) begin : g_nibble
    logic [3:0] w_pn;
    logic [3:0] w_gn;
    logic [3:0] w_ci;

    assign w_pn = w_p[4*k +: 4];
    assign w_gn = w_g[4*k +: 4];

    assign w_pk[k] = &w_pn;
    assign w_gk[k] = w_gn[3]
                   | (w_pn[3] & w_gn[2])
                   | (w_pn[3] & w_pn[2] & w_gn[1])
                   | (w_pn[3] & w_pn[2] & w_pn[1] & w_gn[0]);

    assign w_c[k+1] = f_group_carry(w_gk, w_pk, w_cin, k);

    // Intra-nibble lookahead from the resolved group carry-in.
    assign w_ci[0] = w_c[k];
    assign w_ci[1] = w_gn[0] | (w_pn[0] & w_c[k]);
    assign w_ci[2] = w_gn[1] | (w_pn[1] & w_gn[0])
                   | (w_pn[1] & w_pn[0] & w_c[k]);
    assign w_ci[3] = w_gn[2] | (w_pn[2] & w_gn[1])
                   | (w_pn[2] & w_pn[1] & w_gn[0])
                   | (w_pn[2] & w_pn[1] & w_pn[0] & w_c[k]);

    assign w_sum[4*k +: 4] = bus.in_a[4*k +: 4] ^ w_b_eff[4*k +: 4] ^ w_ci;

    // The carry into the slice MSB is needed for signed overflow.
    if (k == NG - 1) begin : g_msb
      assign w_cmsb = w_ci[3];
    end
  end

  assign w_zacc_d = (w_first_eff ? 1'b1 : zacc_q) & (w_sum == '0);

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (w_accept) begin
      state_d = bus.in_last ? S_IDLE : S_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      zacc_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        carry_q <= w_c[NG];
        sub_q   <= w_sub;
        zacc_q  <= w_zacc_d;
      end
    end
  end

  // Output register: loaded on accept, emptied on drain, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovfl_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_abort_q <= 1'b0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= w_sum;
      out_cout_q  <= w_c[NG];
      out_ovfl_q  <= bus.in_last & (w_c[NG] ^ w_cmsb);
      out_zero_q  <= bus.in_last & w_zacc_d;
      out_last_q  <= bus.in_last;
      out_abort_q <= w_abort;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovfl  = out_ovfl_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_abort = out_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_multiword_adder
// Purpose  : Self-checking bench for cla_multiword_adder.
//            It runs directed scenarios with fixed expected values, then a
//            randomized run.
//            The randomized run is scored against an arithmetic model of the
//            chained add/sub.
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_multiword_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_multiword_adder_if #(.WIDTH(W)) bus ();

  cla_multiword_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed result tuple: {sum, cout, ovfl, zero, last, abort}
  logic [W+4:0] obs;
  assign obs = {bus.out_sum, bus.out_cout, bus.out_ovfl, bus.out_zero,
                bus.out_last, bus.out_abort};

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model state ----------------
  bit           m_busy;
  bit           m_carry;
  bit           m_sub;
  bit           m_zacc;
  logic [W+4:0] exp_q[$];

  function automatic logic [W+4:0] model_beat(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input bit sub_in,
                                              input bit first,
                                              input bit last);
    bit          fe;
    bit          abort;
    bit          s;
    logic [W-1:0] beff;
    logic [W:0]   full;
    bit          ovfl;
    bit          z;
    fe    = first || !m_busy;
    abort = m_busy ? first : !first;
    s     = fe ? sub_in : m_sub;
    beff  = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (fe ? s : m_carry)};
    // Signed overflow: both addends share a sign and the result sign differs.
    ovfl  = last && (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    z     = (fe ? 1'b1 : m_zacc) && (full[W-1:0] == '0);
    m_carry = full[W];
    m_sub   = s;
    m_zacc  = z;
    m_busy  = !last;
    return {full[W-1:0], full[W], ovfl, z && last, last, abort};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit sub, input bit first, input bit last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_first = first;
    bus.in_last  = last;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_in();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    n_total++;
    if (bus.out_valid !== 1'b0 || obs !== '0)
      $display("FAIL reset_outputs: got valid=%b tuple=%h, want valid=0 tuple=0",
               bus.out_valid, obs);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    put(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    n_total++;
    if (bus.out_valid !== 1'b1 || obs !== {16'h8000, 5'b01010})
      $display("FAIL single_add: got valid=%b tuple=%h want valid=1 tuple=%h",
               bus.out_valid, obs, {16'h8000, 5'b01010});
    else n_pass++;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL single_add_drain: got valid=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_two_beat_add();
    put(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    step();
    n_total++;
    if (obs !== {16'h0000, 5'b10000})
      $display("FAIL two_beat_add_b0: got %h want %h", obs, {16'h0000, 5'b10000});
    else n_pass++;
    put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    n_total++;
    if (obs !== {16'h0001, 5'b00010})
      $display("FAIL two_beat_add_b1: got %h want %h", obs, {16'h0001, 5'b00010});
    else n_pass++;
    step();
  endtask

  task automatic test_sub_equal();
    put(16'h5678, 16'h5678, 1'b1, 1'b1, 1'b0);
    step();
    n_total++;
    if (obs !== {16'h0000, 5'b10000})
      $display("FAIL sub_equal_b0: got %h want %h", obs, {16'h0000, 5'b10000});
    else n_pass++;
    // in_sub low here: the chain must keep subtracting.
    put(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    n_total++;
    if (obs !== {16'h0000, 5'b10110})
      $display("FAIL sub_equal_b1: got %h want %h", obs, {16'h0000, 5'b10110});
    else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    put(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    step();
    put(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          obs !== {16'h0000, 5'b10000})
        $display("FAIL backpressure_hold%0d: got ready=%b valid=%b tuple=%h want ready=0 valid=1 tuple=%h",
                 i, bus.in_ready, bus.out_valid, obs, {16'h0000, 5'b10000});
      else n_pass++;
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL backpressure_release_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    step();
    idle_in();
    n_total++;
    if (bus.out_valid !== 1'b1 || obs !== {16'h0001, 5'b00010})
      $display("FAIL backpressure_b1: got valid=%b tuple=%h want valid=1 tuple=%h",
               bus.out_valid, obs, {16'h0001, 5'b00010});
    else n_pass++;
    step();
  endtask

  task automatic test_abort();
    put(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    step();
    put(16'h0002, 16'h0003, 1'b0, 1'b1, 1'b1);
    step();
    n_total++;
    if (obs !== {16'h0005, 5'b00011})
      $display("FAIL abort_restart: got %h want %h", obs, {16'h0005, 5'b00011});
    else n_pass++;
    // Back in IDLE: a non-first beat starts fresh (cin from in_sub) and aborts.
    put(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    n_total++;
    if (obs !== {16'h0002, 5'b00011})
      $display("FAIL abort_idle_nonfirst: got %h want %h", obs, {16'h0002, 5'b00011});
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_chain();
    put(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_mid_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    #3;
    rst_n = 1'b1;
    put(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    n_total++;
    if (bus.out_valid !== 1'b1 || obs !== {16'h0002, 5'b00010})
      $display("FAIL reset_mid_after: got valid=%b tuple=%h want valid=1 tuple=%h",
               bus.out_valid, obs, {16'h0002, 5'b00010});
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+4:0] e;
    bit           fst;
    bit           ir_exp;
    idle_in();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_busy  = 0;
    m_carry = 0;
    m_sub   = 0;
    m_zacc  = 1;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a   = W'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      fst = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 15) != 0);
      put(a, b, 1'($urandom_range(0, 1)), fst, $urandom_range(0, 2) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ir_exp = (exp_q.size() == 0) || bus.out_ready;
      n_total++;
      if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== ir_exp)
        $display("FAIL rand_handshake cyc %0d: got valid=%b ready=%b want valid=%b ready=%b",
                 cyc, bus.out_valid, bus.in_ready, exp_q.size() != 0, ir_exp);
      else n_pass++;
      if (exp_q.size() != 0 && bus.out_ready) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e)
          $display("FAIL rand_result cyc %0d: got %h want %h", cyc, obs, e);
        else n_pass++;
      end
      if (bus.in_valid && ir_exp)
        exp_q.push_back(model_beat(a, bus.in_b, bus.in_sub, bus.in_first,
                                   bus.in_last));
      step();
    end
    idle_in();
    bus.out_ready = 1'b1;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (bus.out_valid !== 1'b1 || obs !== e)
        $display("FAIL rand_final: got valid=%b tuple=%h want valid=1 tuple=%h",
                 bus.out_valid, obs, e);
      else n_pass++;
    end
    step();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rand_drained: got valid=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  initial begin
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    idle_in();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_single_add();
    test_two_beat_add();
    test_sub_equal();
    test_backpressure();
    test_abort();
    test_reset_mid_chain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
